// File: rtl/decode_pipe_ctrl.sv
// IF/ID + ID/EX control pipeline for an RV32I subset: decode, load-use stall, branch/jump flush.
// Optional ILLEGAL_TRAP_EN adds a registered illegal_out flag alongside the ID/EX bundle.
module decode_pipe_ctrl #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               instr_in,
  input  logic [PC_WIDTH-1:0]       pc_in,
  input  logic                      instr_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mem_read,
  input  logic                      flush,
  output logic                      stall_out,
  output logic                      id_valid,
  output logic                      reg_write,
  output logic [1:0]                result_src,
  output logic                      mem_write,
  output logic                      alu_src,
  output logic [3:0]                alu_ctrl,
  output logic                      branch,
  output logic [2:0]                br_funct3,
  output logic                      jump,
  output logic                      jalr,
  output logic [XLEN-1:0]           imm_op,
  output logic [REG_ADDR_WIDTH-1:0] rs1,
  output logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [PC_WIDTH-1:0]       pc_out
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                      illegal_out
`endif
);

  localparam logic [6:0] OpcReg    = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluSll  = 4'b0110;
  localparam logic [3:0] AluSrl  = 4'b0111;
  localparam logic [3:0] AluSra  = 4'b1000;
  localparam logic [3:0] AluSltu = 4'b1001;

  // SUB only exists for register-register ops; SRA is selected by bit 30 for both forms.
  function automatic logic [3:0] alu_op(logic [2:0] f3, logic alt, logic is_reg);
    alu_op = AluAdd;
    unique case (f3)
      3'b000: alu_op = (alt && is_reg) ? AluSub : AluAdd;
      3'b001: alu_op = AluSll;
      3'b010: alu_op = AluSlt;
      3'b011: alu_op = AluSltu;
      3'b100: alu_op = AluXor;
      3'b101: alu_op = alt ? AluSra : AluSrl;
      3'b110: alu_op = AluOr;
      3'b111: alu_op = AluAnd;
    endcase
  endfunction

  // IF/ID stage
  logic                ifid_valid_q, ifid_valid_d;
  logic [31:0]         ifid_instr_q, ifid_instr_d;
  logic [PC_WIDTH-1:0] ifid_pc_q, ifid_pc_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [REG_ADDR_WIDTH-1:0] rs1_field, rs2_field, rd_field;

  assign opcode    = ifid_instr_q[6:0];
  assign funct3    = ifid_instr_q[14:12];
  assign funct7    = ifid_instr_q[31:25];
  assign rd_field  = REG_ADDR_WIDTH'(ifid_instr_q[11:7]);
  assign rs1_field = REG_ADDR_WIDTH'(ifid_instr_q[19:15]);
  assign rs2_field = REG_ADDR_WIDTH'(ifid_instr_q[24:20]);

  assign imm_i = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
  assign imm_s = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
  assign imm_b = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                  ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};
  assign imm_j = {{11{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[19:12],
                  ifid_instr_q[20], ifid_instr_q[30:21], 1'b0};
  assign imm_u = {ifid_instr_q[31:12], 12'b0};

  logic        dec_legal;
  logic        dec_reg_write;
  logic [1:0]  dec_result_src;
  logic        dec_mem_write;
  logic        dec_alu_src;
  logic [3:0]  dec_alu_ctrl;
  logic        dec_branch;
  logic        dec_jump;
  logic        dec_jalr;
  logic [31:0] dec_imm;
  logic        dec_rs1_zero;
  logic        use_rs1;
  logic        use_rs2;

  always_comb begin
    dec_legal      = 1'b1;
    dec_reg_write  = 1'b0;
    dec_result_src = 2'b00;
    dec_mem_write  = 1'b0;
    dec_alu_src    = 1'b0;
    dec_alu_ctrl   = AluAdd;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_jalr       = 1'b0;
    dec_imm        = '0;
    dec_rs1_zero   = 1'b0;
    use_rs1        = 1'b0;
    use_rs2        = 1'b0;
    unique case (opcode)
      OpcReg: begin
        dec_reg_write = 1'b1;
        dec_alu_ctrl  = alu_op(funct3, ifid_instr_q[30], 1'b1);
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec_legal     = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OpcImm: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_ctrl  = alu_op(funct3, ifid_instr_q[30], 1'b0);
        dec_imm       = imm_i;
        use_rs1       = 1'b1;
        // Only the shift forms reserve the upper immediate bits as funct7.
        if (funct3 == 3'b001) begin
          dec_legal = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end
      end
      OpcLoad: begin
        dec_reg_write  = 1'b1;
        dec_result_src = 2'b01;
        dec_alu_src    = 1'b1;
        dec_imm        = imm_i;
        use_rs1        = 1'b1;
      end
      OpcStore: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm       = imm_s;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OpcBranch: begin
        dec_branch   = 1'b1;
        dec_alu_ctrl = AluSub;
        dec_imm      = imm_b;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      OpcJal: begin
        dec_reg_write  = 1'b1;
        dec_result_src = 2'b10;
        dec_jump       = 1'b1;
        dec_imm        = imm_j;
      end
      OpcJalr: begin
        dec_reg_write  = 1'b1;
        dec_result_src = 2'b10;
        dec_jump       = 1'b1;
        dec_jalr       = 1'b1;
        dec_alu_src    = 1'b1;
        dec_imm        = imm_i;
        use_rs1        = 1'b1;
      end
      OpcLui: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm       = imm_u;
        dec_rs1_zero  = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  logic hazard;
  logic rs1_hit, rs2_hit;
  logic load_bundle;

  assign rs1_hit     = use_rs1 && (ex_rd == rs1_field);
  assign rs2_hit     = use_rs2 && (ex_rd == rs2_field);
  assign hazard      = ifid_valid_q && ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  assign stall_out   = hazard && !flush;
  assign load_bundle = ifid_valid_q && dec_legal && !hazard && !flush;

  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    if (flush) begin
      ifid_valid_d = 1'b0;
    end else if (!hazard) begin
      ifid_valid_d = instr_valid;
      ifid_instr_d = instr_in;
      ifid_pc_d    = pc_in;
    end
  end

  // ID/EX stage
  logic                      id_valid_q, id_valid_d;
  logic                      reg_write_q, reg_write_d;
  logic [1:0]                result_src_q, result_src_d;
  logic                      mem_write_q, mem_write_d;
  logic                      alu_src_q, alu_src_d;
  logic [3:0]                alu_ctrl_q, alu_ctrl_d;
  logic                      branch_q, branch_d;
  logic [2:0]                br_funct3_q, br_funct3_d;
  logic                      jump_q, jump_d;
  logic                      jalr_q, jalr_d;
  logic [XLEN-1:0]           imm_q, imm_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [PC_WIDTH-1:0]       pc_q, pc_d;

  // Bubbles are all-zero bundles, not just id_valid low.
  always_comb begin
    id_valid_d   = 1'b0;
    reg_write_d  = 1'b0;
    result_src_d = 2'b00;
    mem_write_d  = 1'b0;
    alu_src_d    = 1'b0;
    alu_ctrl_d   = AluAdd;
    branch_d     = 1'b0;
    br_funct3_d  = 3'b000;
    jump_d       = 1'b0;
    jalr_d       = 1'b0;
    imm_d        = '0;
    rs1_d        = '0;
    rs2_d        = '0;
    rd_d         = '0;
    pc_d         = '0;
    if (load_bundle) begin
      id_valid_d   = 1'b1;
      reg_write_d  = dec_reg_write;
      result_src_d = dec_result_src;
      mem_write_d  = dec_mem_write;
      alu_src_d    = dec_alu_src;
      alu_ctrl_d   = dec_alu_ctrl;
      branch_d     = dec_branch;
      br_funct3_d  = dec_branch ? funct3 : 3'b000;
      jump_d       = dec_jump;
      jalr_d       = dec_jalr;
      imm_d        = XLEN'($signed(dec_imm));
      rs1_d        = dec_rs1_zero ? '0 : rs1_field;
      rs2_d        = rs2_field;
      rd_d         = rd_field;
      pc_d         = ifid_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      id_valid_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= AluAdd;
      branch_q     <= 1'b0;
      br_funct3_q  <= 3'b000;
      jump_q       <= 1'b0;
      jalr_q       <= 1'b0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      pc_q         <= '0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      id_valid_q   <= id_valid_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      mem_write_q  <= mem_write_d;
      alu_src_q    <= alu_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
      branch_q     <= branch_d;
      br_funct3_q  <= br_funct3_d;
      jump_q       <= jump_d;
      jalr_q       <= jalr_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      pc_q         <= pc_d;
    end
  end

  assign id_valid   = id_valid_q;
  assign reg_write  = reg_write_q;
  assign result_src = result_src_q;
  assign mem_write  = mem_write_q;
  assign alu_src    = alu_src_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign branch     = branch_q;
  assign br_funct3  = br_funct3_q;
  assign jump       = jump_q;
  assign jalr       = jalr_q;
  assign imm_op     = imm_q;
  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign rd         = rd_q;
  assign pc_out     = pc_q;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // A stalled entry reports once, when it finally leaves IF/ID.
  assign illegal_d = ifid_valid_q && !dec_legal && !hazard && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal_out = illegal_q;
`endif

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// Randomised bench for decode_pipe_ctrl against a queue-free behavioural pipeline model,
// plus directed literal checks for the documented instruction examples.
module tb_decode_pipe_ctrl;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpL    = 7'b0000011;
  localparam logic [6:0] OpS    = 7'b0100011;
  localparam logic [6:0] OpB    = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111;
  localparam logic [6:0] OpLui  = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_in = '0;
  logic [31:0] pc_in = '0;
  logic        instr_valid = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_mem_read = 1'b0;
  logic        flush = 1'b0;
  logic        stall_out, id_valid, reg_write, mem_write, alu_src, branch, jump, jalr;
  logic [1:0]  result_src;
  logic [3:0]  alu_ctrl;
  logic [2:0]  br_funct3;
  logic [31:0] imm_op, pc_out;
  logic [4:0]  rs1, rs2, rd;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal_out;
  logic        m_ill = 1'b0;
`endif

  always #5 clk = ~clk;

  decode_pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .pc_in(pc_in),
    .instr_valid(instr_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .flush(flush),
    .stall_out(stall_out), .id_valid(id_valid), .reg_write(reg_write),
    .result_src(result_src), .mem_write(mem_write), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .branch(branch), .br_funct3(br_funct3), .jump(jump), .jalr(jalr), .imm_op(imm_op),
    .rs1(rs1), .rs2(rs2), .rd(rd), .pc_out(pc_out)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_out(illegal_out)
`endif
  );

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic        branch;
    logic [2:0]  br_funct3;
    logic        jump;
    logic        jalr;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
  } bundle_t;

  bundle_t     dut_b;
  bundle_t     m_ex = '0;
  logic        m_if_valid = 1'b0;
  logic [31:0] m_if_instr = '0;
  logic [31:0] m_if_pc = '0;
  int          checks = 0;
  int          errors = 0;

  assign dut_b = {id_valid, reg_write, result_src, mem_write, alu_src, alu_ctrl, branch,
                  br_funct3, jump, jalr, imm_op, rs1, rs2, rd, pc_out};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] ins);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    if (!(op inside {OpR, OpI, OpL, OpS, OpB, OpJal, OpJalr, OpLui})) return 1'b0;
    if (op == OpR) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (op == OpI && f3 == 3'd1) return f7 == 7'h00;
    if (op == OpI && f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
    return 1'b1;
  endfunction

  // {uses rs1, uses rs2}
  function automatic logic [1:0] uses(input logic [31:0] ins);
    logic [6:0] op = ins[6:0];
    if (op inside {OpR, OpS, OpB}) return 2'b11;
    if (op inside {OpI, OpL, OpJalr}) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t    b;
    int         si;
    logic [6:0] op;
    logic [2:0] f3;
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
    b  = '0;
    si = int'($signed(ins));
    op = ins[6:0];
    f3 = ins[14:12];
    if (!legal(ins)) return b;
    b.valid      = 1'b1;
    b.pc         = pc;
    b.rs1        = (op == OpLui) ? 5'd0 : ins[19:15];
    b.rs2        = ins[24:20];
    b.rd         = ins[11:7];
    b.reg_write  = !(op inside {OpS, OpB});
    b.alu_src    = op inside {OpI, OpL, OpS, OpJalr, OpLui};
    b.mem_write  = (op == OpS);
    b.result_src = (op == OpL) ? 2'd1 : (op inside {OpJal, OpJalr}) ? 2'd2 : 2'd0;
    b.branch     = (op == OpB);
    b.br_funct3  = b.branch ? f3 : 3'd0;
    b.jump       = op inside {OpJal, OpJalr};
    b.jalr       = (op == OpJalr);
    if (op inside {OpR, OpI}) begin
      b.alu_ctrl = tbl[f3];
      if (f3 == 3'd5 && ins[30]) b.alu_ctrl = 4'd8;
      if (f3 == 3'd0 && ins[30] && op == OpR) b.alu_ctrl = 4'd1;
    end else if (op == OpB) begin
      b.alu_ctrl = 4'd1;
    end
    if (op inside {OpI, OpL, OpJalr}) b.imm = 32'(si >>> 20);
    if (op == OpS) b.imm = 32'(((si >>> 25) <<< 5) | int'(ins[11:7]));
    if (op == OpB) b.imm = 32'(((si >>> 31) <<< 12) | (int'(ins[7]) << 11) |
                               (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1));
    if (op == OpJal) b.imm = 32'(((si >>> 31) <<< 20) | (int'(ins[19:12]) << 12) |
                                 (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1));
    if (op == OpLui) b.imm = ins & 32'hFFFF_F000;
    return b;
  endfunction

  // One clock: drive at negedge, check the combinational stall, step the model, check ID/EX.
  task automatic cycle(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                       input logic [4:0] erd, input logic emr, input logic fl,
                       output logic stall_seen);
    logic       hz;
    logic [1:0] u;
    @(negedge clk);
    instr_in = ins; pc_in = pc; instr_valid = v; ex_rd = erd; ex_mem_read = emr; flush = fl;
    #1;
    u  = uses(m_if_instr);
    hz = m_if_valid && emr && (erd != 5'd0) &&
         ((u[1] && erd == m_if_instr[19:15]) || (u[0] && erd == m_if_instr[24:20]));
    check("stall_out", 128'(stall_out), 128'(hz && !fl));
    stall_seen = stall_out;
    if (fl) begin
      m_ex = '0;
      m_if_valid = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      m_ill = 1'b0;
`endif
    end else if (hz) begin
      m_ex = '0;
`ifdef ILLEGAL_TRAP_EN
      m_ill = 1'b0;
`endif
    end else begin
      m_ex = m_if_valid ? model_decode(m_if_instr, m_if_pc) : '0;
`ifdef ILLEGAL_TRAP_EN
      m_ill = m_if_valid && !legal(m_if_instr);
`endif
      m_if_valid = v;
      m_if_instr = ins;
      m_if_pc    = pc;
    end
    @(posedge clk);
    #1;
    check("idex_bundle", 128'(dut_b), 128'(m_ex));
`ifdef ILLEGAL_TRAP_EN
    check("illegal_out", 128'(illegal_out), 128'(m_ill));
`endif
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [10];
    int          k;
    ops = '{OpR, OpI, OpL, OpS, OpB, OpJal, OpJalr, OpLui, 7'b1111111, 7'b0001111};
    r = $urandom;
    k = $urandom_range(0, 99);
    r[6:0]   = ops[$urandom_range(0, 9)];
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    if (k < 55) r[31:25] = 7'h00;
    else if (k < 85) r[31:25] = 7'h20;
    return r;
  endfunction

  task automatic model_reset();
    m_ex = '0;
    m_if_valid = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    m_ill = 1'b0;
`endif
  endtask

  logic s;

  initial begin
    #12 rst_n = 1'b1;
    check("reset_bundle", 128'(dut_b), 128'(0));
    check("reset_stall", 128'(stall_out), 128'(0));

    // addi x1,x0,5
    cycle(32'h0050_0093, 32'h100, 1'b1, 5'd0, 1'b0, 1'b0, s);
    cycle(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, s);
    check("addi_valid", 128'(id_valid), 128'(1));
    check("addi_regwrite", 128'(reg_write), 128'(1));
    check("addi_alusrc", 128'(alu_src), 128'(1));
    check("addi_aluctrl", 128'(alu_ctrl), 128'(0));
    check("addi_imm", 128'(imm_op), 128'(5));
    check("addi_rd", 128'(rd), 128'(1));
    check("addi_pc", 128'(pc_out), 128'(32'h100));

    // sub x5,x6,x7
    cycle(32'h4073_02B3, 32'h104, 1'b1, 5'd0, 1'b0, 1'b0, s);
    cycle(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, s);
    check("sub_aluctrl", 128'(alu_ctrl), 128'(1));
    check("sub_rs1", 128'(rs1), 128'(6));
    check("sub_rs2", 128'(rs2), 128'(7));
    check("sub_rd", 128'(rd), 128'(5));
    check("sub_alusrc", 128'(alu_src), 128'(0));

    // beq x1,x2,-4
    cycle(32'hFE20_8EE3, 32'h108, 1'b1, 5'd0, 1'b0, 1'b0, s);
    cycle(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, s);
    check("beq_branch", 128'(branch), 128'(1));
    check("beq_funct3", 128'(br_funct3), 128'(0));
    check("beq_imm", 128'(imm_op), 128'(32'hFFFF_FFFC));
    check("beq_regwrite", 128'(reg_write), 128'(0));

    // Load-use on add x3,x2,x1 with the load writing x2
    cycle(32'h0011_01B3, 32'h200, 1'b1, 5'd0, 1'b0, 1'b0, s);
    cycle(32'h0, 32'h0, 1'b0, 5'd2, 1'b1, 1'b0, s);
    check("lu_stall", 128'(s), 128'(1));
    check("lu_bubble", 128'(id_valid), 128'(0));
    cycle(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, s);
    check("lu_release", 128'(s), 128'(0));
    check("lu_add_valid", 128'(id_valid), 128'(1));
    check("lu_add_rd", 128'(rd), 128'(3));
    check("lu_add_pc", 128'(pc_out), 128'(32'h200));

    // Same with ex_rd = x0: no stall
    cycle(32'h0011_01B3, 32'h204, 1'b1, 5'd0, 1'b0, 1'b0, s);
    cycle(32'h0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, s);
    check("lu_x0_stall", 128'(s), 128'(0));
    check("lu_x0_valid", 128'(id_valid), 128'(1));

    // Hazard and flush together; addi offered during the flush must be dropped
    cycle(32'h0011_01B3, 32'h300, 1'b1, 5'd0, 1'b0, 1'b0, s);
    cycle(32'h0050_0093, 32'h304, 1'b1, 5'd2, 1'b1, 1'b1, s);
    check("fl_stall", 128'(s), 128'(0));
    check("fl_idex", 128'(id_valid), 128'(0));
    cycle(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, s);
    check("fl_ifid_dead", 128'(id_valid), 128'(0));
    cycle(32'h0050_0093, 32'h400, 1'b1, 5'd0, 1'b0, 1'b0, s);
    cycle(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, s);
    check("fl_after_valid", 128'(id_valid), 128'(1));
    check("fl_after_pc", 128'(pc_out), 128'(32'h400));

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        // Asynchronous reset mid-stream, away from any clock edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_bundle", 128'(dut_b), 128'(0));
        check("midrst_stall", 128'(stall_out), 128'(0));
        model_reset();
        instr_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(32'h0050_0093, 32'h500, 1'b1, 5'd0, 1'b0, 1'b0, s);
        check("midrst_one_edge", 128'(id_valid), 128'(0));
        cycle(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, s);
        check("midrst_two_edges", 128'(id_valid), 128'(1));
        check("midrst_pc", 128'(pc_out), 128'(32'h500));
      end
      cycle(rand_instr(), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 99) < 85),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 99) < 40),
            1'($urandom_range(0, 99) < 10), s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_pipe_ctrl.md
Name: decode_pipe_ctrl

Overview:
Pipelined successor to the single-cycle control path. Registers the fetched instruction into an IF/ID stage, decodes it, and registers a full control bundle into an ID/EX stage. Detects load-use hazards and flushes on a taken branch or jump. Widths are parametrised, and the block covers the wider RV32I subset with a 4-bit ALU control.

Parameters:
XLEN, 32, datapath and immediate width
PC_WIDTH, 32, program counter width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
instr_in  in  32  fetched instruction
pc_in  in  PC_WIDTH  PC of instr_in
instr_valid  in  1  instr_in/pc_in valid this cycle
ex_rd  in  REG_ADDR_WIDTH  destination register of the instruction currently in EX
ex_mem_read  in  1  instruction in EX is a load
flush  in  1  branch/jump taken in EX; kill younger instructions
stall_out  out  1  hold fetch (PC and instr_in) this cycle
id_valid  out  1  ID/EX bundle valid
reg_write  out  1  register write enable
result_src  out  2  00 ALU, 01 memory, 10 PC+4
mem_write  out  1  memory write enable
alu_src  out  1  0 = rs2, 1 = immediate
alu_ctrl  out  4  ALU operation
branch  out  1  conditional branch; funct3 carried on br_funct3
br_funct3  out  3  branch condition
jump  out  1  JAL/JALR
jalr  out  1  target = rs1 + imm
imm_op  out  XLEN  sign-extended immediate
rs1, rs2, rd  out  REG_ADDR_WIDTH each  register fields
pc_out  out  PC_WIDTH  PC of the instruction in ID/EX

Behaviour:
- Reset (async, rst_n=0): every ID/EX output = 0, IF/ID valid = 0, stall_out = 0.
- Latency: instr_in is captured into IF/ID at edge N. Its decoded bundle appears on the outputs after edge N+1 (2 cycles), absent stall or flush.
- Decode from the IF/ID instruction:
  - R-type 0110011: alu_src 0.
  - I-ALU 0010011: alu_src 1.
  - LOAD 0000011: result_src 01, alu ADD.
  - STORE 0100011: mem_write 1, reg_write 0, S-immediate.
  - BRANCH 1100011: branch 1, alu SUB, B-immediate.
  - JAL 1101111: jump 1, result_src 10, J-immediate.
  - JALR 1100111: jump 1, jalr 1, result_src 10.
  - LUI 0110111: U-immediate; ALU computes x0 + imm, so rs1 is forced to 0.
- alu_ctrl encodings: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, SLTU 1001.
  - SUB applies only to R-type with instr[30]=1.
  - SRA applies when funct3=101 and instr[30]=1, for both R-type and I-type.
- Register usage for the hazard check:
  - R, STORE, BRANCH use rs1 and rs2.
  - I-ALU, LOAD, JALR use rs1 only.
  - JAL and LUI use neither.
- Load-use hazard: asserted when IF/ID is valid, ex_mem_read=1, ex_rd≠0, and ex_rd matches a used source register. On a hazard, combinationally:
  - stall_out=1.
  - IF/ID holds its contents.
  - ID/EX loads a bubble: id_valid=0, all enables 0.
  - The hazard clears the following cycle once the load has advanced.
- flush=1 takes priority over a hazard and over instr_valid:
  - IF/ID valid and ID/EX id_valid both clear at the next edge.
  - stall_out is 0 during flush.
- instr_valid=0 with no stall: IF/ID valid clears and a bubble propagates.
- An invalid IF/ID entry always produces a bubble.
- Unknown opcode: produces a bubble (id_valid=0). It never writes registers or memory.
- rd=0 with reg_write=1 is passed through unchanged; the register file ignores the write.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: adds output illegal_out (1 bit), registered with the ID/EX stage. It is 1 for one cycle when a valid IF/ID entry has an unknown opcode, or an unknown funct3/funct7 for R-type or I-ALU. The bundle is still a bubble.
- Undefined: the port is absent and illegal encodings silently become bubbles.

Test Plan:
1. Reset mid-stream: rst_n low asynchronously → all outputs 0 immediately. First instruction after release appears on outputs 2 cycles later.
2. instr_in=0x00500093 (addi x1,x0,5), pc_in=0x100 → after 2 edges:
   - id_valid=1, reg_write=1, alu_src=1, alu_ctrl=0000.
   - imm_op=5, rd=1, pc_out=0x100.
3. instr_in=0x407302B3 (sub x5,x6,x7) → alu_ctrl=0001, rs1=6, rs2=7, rd=5, alu_src=0.
4. instr_in=0xFE208EE3 (beq x1,x2,-4) → branch=1, br_funct3=000, imm_op=0xFFFFFFFC, reg_write=0.
5. Load-use: IF/ID holds 0x001101B3 (add x3,x2,x1) with ex_mem_read=1, ex_rd=2 → stall_out=1 for one cycle, then a bubble (id_valid=0). The add appears the following cycle. Repeat with ex_rd=0 → no stall.
6. Hazard with flush=1 in the same cycle → stall_out=0. Both stages are invalid after the edge; the next valid instr_in decodes normally.
